// File: rtl/seq_multiplier_pkg.sv
// rtl/seq_multiplier_pkg.sv - shared width default, FSM states and counter sizing for seq_multiplier
package seq_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int count_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/seq_multiplier_datapath.sv
// rtl/seq_multiplier_datapath.sv - operand/accumulator registers, shift-add step and final sign fix-up
module seq_multiplier_datapath
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_final,
    input  logic             i_is_signed,
    input  logic [WIDTH-1:0] i_busa,
    input  logic [WIDTH-1:0] i_busb,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [WIDTH-1:0]   r_acc;
    logic               r_neg;
    logic [WIDTH-1:0]   r_prod_hi;
    logic [WIDTH-1:0]   r_prod_lo;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_result;
    logic [2*WIDTH-1:0] w_final_prod;

    // Most-negative input negates to itself, which read unsigned is exactly 2^(WIDTH-1).
    assign w_mag_a = (i_is_signed && i_busa[WIDTH-1]) ? (~i_busa + WIDTH'(1)) : i_busa;
    assign w_mag_b = (i_is_signed && i_busb[WIDTH-1]) ? (~i_busb + WIDTH'(1)) : i_busb;

    assign w_addend     = r_mplier[0] ? r_mcand : '0;
    assign w_sum        = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_result     = {w_sum, r_mplier[WIDTH-1:1]};
    assign w_final_prod = r_neg ? (~w_result + (2*WIDTH)'(1)) : w_result;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_prod_hi <= '0;
            r_prod_lo <= '0;
        end else begin
            if (i_load) begin
                r_mcand  <= w_mag_a;
                r_mplier <= w_mag_b;
                r_acc    <= '0;
                r_neg    <= i_is_signed & (i_busa[WIDTH-1] ^ i_busb[WIDTH-1]);
            end else if (i_step) begin
                r_acc    <= w_sum[WIDTH:1];
                r_mplier <= {w_sum[0], r_mplier[WIDTH-1:1]};
            end
            if (i_final) begin
                {r_prod_hi, r_prod_lo} <= w_final_prod;
            end
        end
    end

    assign o_prod_hi = r_prod_hi;
    assign o_prod_lo = r_prod_lo;

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add MULT/MULTU unit: FSM, step counter and datapath instance
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo
);

    localparam int CNT_W = count_width(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_count;
    logic             w_load;
    logic             w_step;
    logic             w_final;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= ST_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_count <= CNT_W'(WIDTH - 1);
            end else if (w_step && !w_final) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_final      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_count == '0) begin
                    w_final      = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_load       = start;
                w_next_state = start ? ST_RUN : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Both flags decode the state register only, so nothing combinational reaches them from inputs.
    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

    seq_multiplier_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .arst        (arst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_final     (w_final),
        .i_is_signed (is_signed),
        .i_busa      (busA),
        .i_busb      (busB),
        .o_prod_hi   (prod_hi),
        .o_prod_lo   (prod_lo)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier against an arithmetic reference
module tb_seq_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         arst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic         busy;
    logic         done;
    logic [W-1:0] prod_hi;
    logic [W-1:0] prod_lo;

    int n_checks;
    int n_fail;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk       (clk),
        .arst      (arst),
        .start     (start),
        .is_signed (is_signed),
        .busA      (busA),
        .busB      (busB),
        .busy      (busy),
        .done      (done),
        .prod_hi   (prod_hi),
        .prod_lo   (prod_lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller must be at a tick point with the unit idle or in its done cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [2*W-1:0] exp, input string name);
        busA = a; busB = b; is_signed = s; start = 1'b1;
        tick();
        start = 1'b0;
        busA = $urandom; busB = $urandom; is_signed = $urandom_range(0, 1);
        for (int k = 0; k < W; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_window cycle %0d: busy=%b done=%b expected busy=1 done=0",
                         name, k, busy, done);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL %s result: busy=%b done=%b prod=%h expected busy=0 done=1 prod=%h",
                     name, busy, done, {prod_hi, prod_lo}, exp);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || {prod_hi, prod_lo} !== exp) begin
            n_fail++;
            $display("FAIL %s hold: busy=%b done=%b prod=%h expected busy=0 done=0 prod=%h",
                     name, busy, done, {prod_hi, prod_lo}, exp);
        end
    endtask

    task automatic test_reset();
        arst = 1'b1; start = 1'b0; is_signed = 1'b0; busA = '0; busB = '0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod_hi !== '0 || prod_lo !== '0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all zero",
                     busy, done, prod_hi, prod_lo);
        end
        @(negedge clk);
        arst = 1'b0;
        tick();
    endtask

    task automatic test_directed();
        run_op(32'd3, 32'd5, 1'b0, 64'h00000000_0000000F, "u3x5");
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, "umax_sq");
        run_op(32'hFFFFFFFF, 32'd1, 1'b1, 64'hFFFFFFFF_FFFFFFFF, "s_neg1x1");
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 64'h00000000_FFFFFFFF, "u_max_x1");
        run_op(32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, "s_min_sq");
        run_op(32'h80000000, 32'd1, 1'b1, 64'hFFFFFFFF_80000000, "s_min_x1");
        run_op(32'd0, 32'hFFFFFFFF, 1'b1, 64'h0, "s_zero");
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 24; i++) begin
            a = pick_operand();
            b = pick_operand();
            s = $urandom_range(0, 1);
            run_op(a, b, s, model(a, b, s), "random");
        end
    endtask

    task automatic test_ignore_start();
        int n;
        busA = 32'd7; busB = 32'd6; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        repeat (9) begin tick(); n++; end
        busA = 32'd2; busB = 32'd2; is_signed = 1'b1; start = 1'b1;
        tick(); n++;
        start = 1'b0;
        while (done !== 1'b1 && n < 3 * W) begin tick(); n++; end
        n_checks++;
        if (n !== W + 1 || {prod_hi, prod_lo} !== 64'd42) begin
            n_fail++;
            $display("FAIL ignore_start: edges_to_done=%0d prod=%h expected edges=%0d prod=%h",
                     n, {prod_hi, prod_lo}, W + 1, 64'd42);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        logic [2*W-1:0] exp2;
        exp2 = model(32'hFFFF0001, 32'h00012345, 1'b1);
        busA = 32'd7; busB = 32'd6; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        while (done !== 1'b1 && n < 3 * W) begin tick(); n++; end
        n_checks++;
        if (n !== W + 1 || {prod_hi, prod_lo} !== 64'd42) begin
            n_fail++;
            $display("FAIL b2b_first: edges_to_done=%0d prod=%h expected edges=%0d prod=%h",
                     n, {prod_hi, prod_lo}, W + 1, 64'd42);
        end
        busA = 32'hFFFF0001; busB = 32'h00012345; is_signed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || {prod_hi, prod_lo} !== 64'd42) begin
            n_fail++;
            $display("FAIL b2b_accept: busy=%b done=%b prod=%h expected busy=1 done=0 prod=%h",
                     busy, done, {prod_hi, prod_lo}, 64'd42);
        end
        n = 1;
        while (done !== 1'b1 && n < 3 * W) begin tick(); n++; end
        n_checks++;
        if (n !== W + 1 || {prod_hi, prod_lo} !== exp2) begin
            n_fail++;
            $display("FAIL b2b_second: edges_to_done=%0d prod=%h expected edges=%0d prod=%h",
                     n, {prod_hi, prod_lo}, W + 1, exp2);
        end
        tick();
    endtask

    task automatic test_arst_mid_run();
        busA = 32'd1000; busB = 32'd77; is_signed = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (14) tick();
        arst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || prod_hi !== '0 || prod_lo !== '0) begin
            n_fail++;
            $display("FAIL arst_mid_run: busy=%b done=%b hi=%h lo=%h expected all zero",
                     busy, done, prod_hi, prod_lo);
        end
        @(negedge clk);
        arst = 1'b0;
        tick();
        run_op(32'd9, 32'd9, 1'b0, 64'd81, "after_arst_9x9");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        run_op(32'd3, 32'd5, 1'b0, 64'hF, "warmup");
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_arst_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
